// File: rtl/ks_adder_pipe_if.sv
// Operand/result stream bundle for the pipelined Kogge-Stone adder/subtractor.
// A beat moves on a rising clk edge only when its valid and ready are both high;
// valid must not depend on ready, and the data is held stable while valid is high without ready.
interface ks_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one cell stage, one register per prefix
// level, one sum stage. The whole pipe advances together and stalls together.
module ks_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ks_adder_pipe_if.slave  bus
);
    localparam int LEVELS = $clog2(WIDTH);

    logic                         adv;
    logic                         c0;
    logic [WIDTH-1:0]             b_eff;
    logic [WIDTH-1:0]             p_full;
    logic [LEVELS:0]              v_r;
    logic [LEVELS:0]              am_r;
    logic [LEVELS:0]              bm_r;
    logic [LEVELS:0][WIDTH-1:0]   ps_r;
    logic [WIDTH-1:0]             carry;
    logic [WIDTH-1:0]             sum_d;
    logic                         cout_d;
    logic                         ovf_d;
    logic                         out_valid_r;
    logic [WIDTH-1:0]             sum_r;
    logic                         cout_r;
    logic                         ovf_r;

    assign adv          = !out_valid_r || bus.out_ready;
    assign bus.in_ready = adv;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign c0           = bus.sub | bus.cin;
    assign p_full       = bus.a ^ b_eff;

    // Node n carries bit n-1; node 0 is the carry-in (G=c0, P=0). Only nodes 0..WIDTH-1
    // are kept: they are exactly the carries into bits 0..WIDTH-1. P is only kept for
    // nodes that have not yet reached node 0, since it is dead everywhere else.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_stage
        logic [WIDTH-1:0] g_d;
        logic [WIDTH-1:0] g_q;

        if (k == 0) begin : g_src
            assign g_d = {bus.a[WIDTH-2:0] & b_eff[WIDTH-2:0], c0};
        end else begin : g_src
            localparam int D = 1 << (k - 1);
            for (genvar n = 0; n < WIDTH; n++) begin : g_node
                if (n >= D) begin : g_mix
                    assign g_d[n] = g_stage[k-1].g_q[n] |
                                    (g_stage[k-1].g_p.p_q[n] & g_stage[k-1].g_q[n-D]);
                end else begin : g_keep
                    assign g_d[n] = g_stage[k-1].g_q[n];
                end
            end
        end

        if (k < LEVELS) begin : g_p
            localparam int PL = 1 << k;
            logic [WIDTH-1:PL] p_d;
            logic [WIDTH-1:PL] p_q;

            if (k == 0) begin : g_psrc
                assign p_d = p_full[WIDTH-2:0];
            end else begin : g_psrc
                localparam int D = 1 << (k - 1);
                for (genvar n = PL; n < WIDTH; n++) begin : g_pnode
                    assign p_d[n] = g_stage[k-1].g_p.p_q[n] & g_stage[k-1].g_p.p_q[n-D];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_q <= '0;
                end else if (adv) begin
                    p_q <= p_d;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                g_q <= '0;
            end else if (adv) begin
                g_q <= g_d;
            end
        end
    end

    // Carry out of the MSB is rebuilt from the raw MSB cell and the carry into it.
    assign carry  = g_stage[LEVELS].g_q;
    assign sum_d  = ps_r[LEVELS] ^ carry;
    assign cout_d = (am_r[LEVELS] & bm_r[LEVELS]) |
                    ((am_r[LEVELS] ^ bm_r[LEVELS]) & carry[WIDTH-1]);
    assign ovf_d  = carry[WIDTH-1] ^ cout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r         <= '0;
            am_r        <= '0;
            bm_r        <= '0;
            ps_r        <= '0;
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (adv) begin
            v_r         <= {v_r[LEVELS-1:0], bus.in_valid};
            am_r        <= {am_r[LEVELS-1:0], bus.a[WIDTH-1]};
            bm_r        <= {bm_r[LEVELS-1:0], b_eff[WIDTH-1]};
            ps_r        <= {ps_r[LEVELS-1:0], p_full};
            out_valid_r <= v_r[LEVELS];
            sum_r       <= sum_d;
            cout_r      <= cout_d;
            ovf_r       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule
